// File: rtl/lamp_pkg.sv
// Shared sizes and scan FSM state encoding for the lamp scan scheduler.
package lamp_pkg;

  localparam int LAMP_N      = 16;
  localparam int LAMP_ADDR_W = 4;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } lamp_state_e;

endpackage

// File: rtl/lamp_scan_ctrl_if.sv
// Lamp request/drive bundle between requesters and the scan scheduler.
interface lamp_scan_ctrl_if;
  import lamp_pkg::*;

  logic [LAMP_N-1:0]      lamp_req;
  logic                   pause;
  logic [LAMP_ADDR_W-1:0] lamp_addr;
  logic                   lamp_en;
  logic [LAMP_N-1:0]      grant;
  logic                   frame_pulse;

  modport master (
    output lamp_req, pause,
    input  lamp_addr, lamp_en, grant, frame_pulse
  );

  modport slave (
    input  lamp_req, pause,
    output lamp_addr, lamp_en, grant, frame_pulse
  );

endinterface

// File: rtl/lamp_scan_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 15 -> 0.
module rr_pick
  import lamp_pkg::*;
(
  input  logic [LAMP_N-1:0]      req,
  input  logic [LAMP_ADDR_W-1:0] ptr,
  output logic                   found,
  output logic [LAMP_ADDR_W-1:0] idx,
  output logic                   wrapped
);

  logic [LAMP_ADDR_W-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = 0; i < LAMP_N; i++) begin
      w_cand = ptr + LAMP_ADDR_W'(i);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

  assign wrapped = found && (idx < ptr);

endmodule

// File: rtl/lamp_scan_ctrl.sv
// Round-robin lamp scan scheduler: DWELL cycles on per grant, BLANK cycles off between grants.
module lamp_scan_ctrl
  import lamp_pkg::*;
#(
  parameter int unsigned DWELL = 8,
  parameter int unsigned BLANK = 2
) (
  input  logic             clk,
  input  logic             reset,
  lamp_scan_ctrl_if.slave  lamp_bus
);

  if (DWELL == 0 || DWELL > 255) begin : g_bad_dwell
    $error("lamp_scan_ctrl: DWELL must be 1..255");
  end
  if (BLANK > 255) begin : g_bad_blank
    $error("lamp_scan_ctrl: BLANK must be 0..255");
  end

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  lamp_state_e            r_state, w_state_nxt;
  logic [LAMP_ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [LAMP_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic                   r_en, w_en_nxt;
  logic [LAMP_N-1:0]      r_grant, w_grant_nxt;
  logic                   r_frame, w_frame_nxt;

  logic                   w_select;
  logic [LAMP_ADDR_W-1:0] w_pick_ptr;
  logic                   w_found;
  logic [LAMP_ADDR_W-1:0] w_idx;
  logic                   w_wrapped;

  // A gapless re-select out of ON must search from the already-advanced pointer.
  assign w_pick_ptr = (r_state == ST_ON) ? (r_addr + 1'b1) : r_ptr;

  rr_pick u_rr_pick (
    .req     (lamp_bus.lamp_req),
    .ptr     (w_pick_ptr),
    .found   (w_found),
    .idx     (w_idx),
    .wrapped (w_wrapped)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_frame_nxt = 1'b0;
    w_select    = 1'b0;
    w_en_nxt    = 1'b0;
    w_grant_nxt = '0;

    case (r_state)
      ST_IDLE: w_select = 1'b1;
      ST_ON: begin
        if (!lamp_bus.lamp_req[r_addr] || r_cnt == '0) begin
          w_ptr_nxt = r_addr + 1'b1;
          if (BLANK > 0) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = BLANK_LD;
          end else begin
            w_select = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_BLANK: begin
        if (r_cnt == '0) begin
          w_select = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_select) begin
      if (w_found) begin
        w_state_nxt = ST_ON;
        w_addr_nxt  = w_idx;
        w_cnt_nxt   = DWELL_LD;
        w_frame_nxt = w_wrapped;
      end else begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    end

    w_en_nxt    = (w_state_nxt == ST_ON);
    w_grant_nxt = w_en_nxt ? (LAMP_N'(1) << w_addr_nxt) : '0;
  end

  // pause freezes every register, including a frame pulse already on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_grant <= '0;
      r_frame <= 1'b0;
    end else if (!lamp_bus.pause) begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_en    <= w_en_nxt;
      r_grant <= w_grant_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  assign lamp_bus.lamp_addr   = r_addr;
  assign lamp_bus.lamp_en     = r_en;
  assign lamp_bus.grant       = r_grant;
  assign lamp_bus.frame_pulse = r_frame;

endmodule
